// File: rtl/lasr_latch_driver.sv
// lasr_latch_driver: drives set/reset D-latch pins for WRITE/SET/RESET/READ and checks the sampled Q.
// Latency (defaults, accept at edge T): WRITE T+6, SET/RESET T+5, READ T+2 (each +2 with LASR_DRV_SYNC_EN).
// Backpressure: one command in flight; cmd_ready stays low until the response is taken with rsp_ready.
// Optional feature macro: LASR_DRV_SYNC_EN (2-flop synchroniser on LAT_Q, 3-cycle SAMPLE).
module lasr_latch_driver #(
  parameter int SETUP_C = 1,
  parameter int PULSE_W = 2,
  parameter int HOLD_C  = 1,
  parameter int REC_C   = 1,
  parameter int CNT_W   = 4
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_d,
  input  logic       cmd_exp,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_q,
  output logic       rsp_err,
  output logic       LAT_D,
  output logic       LAT_CLK,
  output logic       LAT_SETB,
  output logic       LAT_RSTB,
  input  logic       LAT_Q
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

`ifdef LASR_DRV_SYNC_EN
  localparam int SAMP_C = 3;
`else
  localparam int SAMP_C = 1;
`endif

  localparam longint CNT_MAX = longint'(1) << CNT_W;

  generate
    if (SETUP_C < 1 || PULSE_W < 1 || HOLD_C < 1 || REC_C < 1 || CNT_W < 1) begin : g_bad_min
      $error("lasr_latch_driver: every parameter must be >= 1");
    end
    if (SETUP_C > CNT_MAX || PULSE_W > CNT_MAX || HOLD_C > CNT_MAX ||
        REC_C > CNT_MAX || SAMP_C > CNT_MAX) begin : g_bad_range
      $error("lasr_latch_driver: timing parameter too large for CNT_W");
    end
  endgenerate

  // Down-counter load values: a phase lasting N cycles starts at N-1 and ends when it reaches 0.
  localparam logic [CNT_W-1:0] SETUP_L = CNT_W'(SETUP_C - 1);
  localparam logic [CNT_W-1:0] PULSE_L = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(HOLD_C - 1);
  localparam logic [CNT_W-1:0] REC_L   = CNT_W'(REC_C - 1);
  localparam logic [CNT_W-1:0] SAMP_L  = CNT_W'(SAMP_C - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_OPEN, S_HOLD, S_ASSERT, S_RECOV, S_SAMPLE, S_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       op_r;
  logic             d_r, exp_r;
  logic             accept, cnt_zero, q_in;

  logic cmd_ready_nxt, rsp_valid_nxt, rsp_q_nxt, rsp_err_nxt;
  logic lat_d_nxt, lat_clk_nxt, lat_setb_nxt, lat_rstb_nxt;

  assign accept   = cmd_valid && cmd_ready;
  assign cnt_zero = (cnt == '0);

`ifdef LASR_DRV_SYNC_EN
  logic q_s1, q_s2;

  // Two-stage synchroniser on the latch output before it is sampled.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      q_s1 <= 1'b0;
      q_s2 <= 1'b0;
    end else begin
      q_s1 <= LAT_Q;
      q_s2 <= q_s1;
    end
  end

  assign q_in = q_s2;
`else
  assign q_in = LAT_Q;
`endif

  // State register, phase counter and command capture on accept.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_r  <= OP_WRITE;
      d_r   <= 1'b0;
      exp_r <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_r  <= cmd_op;
        d_r   <= cmd_d;
        exp_r <= cmd_exp;
      end
    end
  end

  // Next-state: walk the phase sequence for the captured op, loading each phase's length.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? cnt : cnt - CNT_W'(1);
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: begin state_nxt = S_SETUP;  cnt_nxt = SETUP_L; end
            OP_SET,
            OP_RESET: begin state_nxt = S_ASSERT; cnt_nxt = PULSE_L; end
            default:  begin state_nxt = S_SAMPLE; cnt_nxt = SAMP_L;  end
          endcase
        end
      end
      S_SETUP:  if (cnt_zero) begin state_nxt = S_OPEN;   cnt_nxt = PULSE_L; end
      S_OPEN:   if (cnt_zero) begin state_nxt = S_HOLD;   cnt_nxt = HOLD_L;  end
      S_HOLD:   if (cnt_zero) begin state_nxt = S_SAMPLE; cnt_nxt = SAMP_L;  end
      S_ASSERT: if (cnt_zero) begin state_nxt = S_RECOV;  cnt_nxt = REC_L;   end
      S_RECOV:  if (cnt_zero) begin state_nxt = S_SAMPLE; cnt_nxt = SAMP_L;  end
      S_SAMPLE: if (cnt_zero) begin state_nxt = S_RESP;   cnt_nxt = '0;      end
      S_RESP:   if (rsp_valid && rsp_ready) begin state_nxt = S_IDLE; cnt_nxt = '0; end
      default:  begin state_nxt = S_IDLE; cnt_nxt = '0; end
    endcase
  end

  // Output decode: pins follow the current phase one cycle later; LAT_D only moves in SETUP.
  always_comb begin
    lat_d_nxt     = (state == S_SETUP) ? d_r : LAT_D;
    lat_clk_nxt   = (state == S_OPEN);
    lat_setb_nxt  = !((state == S_ASSERT) && (op_r == OP_SET));
    lat_rstb_nxt  = !((state == S_ASSERT) && (op_r == OP_RESET));
    cmd_ready_nxt = (state_nxt == S_IDLE);
    rsp_valid_nxt = (state == S_RESP) && !(rsp_valid && rsp_ready);
    rsp_q_nxt     = rsp_q;
    rsp_err_nxt   = rsp_err;
    if ((state == S_SAMPLE) && cnt_zero) begin
      rsp_q_nxt   = q_in;
      rsp_err_nxt = (q_in !== exp_r);
    end
  end

  // Registered outputs; reset parks the pins at their idle levels immediately.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_q     <= 1'b0;
      rsp_err   <= 1'b0;
      LAT_D     <= 1'b0;
      LAT_CLK   <= 1'b0;
      LAT_SETB  <= 1'b1;
      LAT_RSTB  <= 1'b1;
    end else begin
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_q     <= rsp_q_nxt;
      rsp_err   <= rsp_err_nxt;
      LAT_D     <= lat_d_nxt;
      LAT_CLK   <= lat_clk_nxt;
      LAT_SETB  <= lat_setb_nxt;
      LAT_RSTB  <= lat_rstb_nxt;
    end
  end

endmodule

// File: tb/tb_lasr_latch_driver.sv
// tb_lasr_latch_driver: directed vectors through lasr_latch_driver driving a behavioural latch.
// Latency: n/a (bench).
// Backpressure: exercises held responses and busy-time commands.
module tb_lasr_latch_driver;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;
`ifdef LASR_DRV_SYNC_EN
  localparam int EX = 2;
`else
  localparam int EX = 0;
`endif

  logic       CLK = 1'b0;
  logic       RSTB;
  logic       cmd_valid, cmd_ready, cmd_d, cmd_exp;
  logic [1:0] cmd_op;
  logic       rsp_valid, rsp_ready, rsp_q, rsp_err;
  logic       LAT_D, LAT_CLK, LAT_SETB, LAT_RSTB, LAT_Q;

  lasr_latch_driver dut (
    .CLK(CLK), .RSTB(RSTB),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_d(cmd_d), .cmd_exp(cmd_exp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_err(rsp_err),
    .LAT_D(LAT_D), .LAT_CLK(LAT_CLK), .LAT_SETB(LAT_SETB), .LAT_RSTB(LAT_RSTB), .LAT_Q(LAT_Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural set/reset D-latch: reset dominates set, transparent while CLK high.
  logic lat_q_m = 1'b0;
  always @(LAT_D or LAT_CLK or LAT_SETB or LAT_RSTB) begin
    if (!LAT_RSTB)     lat_q_m = 1'b0;
    else if (!LAT_SETB) lat_q_m = 1'b1;
    else if (LAT_CLK)   lat_q_m = LAT_D;
  end
  assign LAT_Q = lat_q_m;

  // Pin activity counters sampled mid-cycle.
  int clk_hi_n = 0, setb_lo_n = 0, rstb_lo_n = 0, overlap_n = 0;
  always @(negedge CLK) begin
    if (LAT_CLK)   clk_hi_n  <= clk_hi_n + 1;
    if (!LAT_SETB) setb_lo_n <= setb_lo_n + 1;
    if (!LAT_RSTB) rstb_lo_n <= rstb_lo_n + 1;
    if ((!LAT_SETB && !LAT_RSTB) || (LAT_CLK && (!LAT_SETB || !LAT_RSTB)))
      overlap_n <= overlap_n + 1;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic       d;
    logic       exp;
    int         lat;
    logic       q;
    logic       err;
    int         clk_w;
    int         setb_w;
    int         rstb_w;
    int         hold;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  logic [63:0] hist_clk, hist_d;

  // Offer one command, then count cycles from the accept edge until rsp_valid.
  task automatic run_cmd(input logic [1:0] op, input logic d, input logic e, output int lat);
    cmd_op = op; cmd_d = d; cmd_exp = e; cmd_valid = 1'b1;
    check("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge CLK); #1;
    cmd_valid = 1'b0; cmd_d = ~d; cmd_exp = ~e;
    check("cmd_ready_after_accept", cmd_ready, 0);
    hist_clk = '0; hist_d = '0;
    lat = 0;
    hist_clk[0] = LAT_CLK; hist_d[0] = LAT_D;
    while (!rsp_valid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      hist_clk[lat] = LAT_CLK; hist_d[lat] = LAT_D;
    end
  endtask

  initial begin
    int lat, c0, s0, r0, seen;
    logic [5:0] clk_bits, d_bits;

    vecs[0] = '{OP_WRITE, 1'b1, 1'b1, 6+EX, 1'b1, 1'b0, 2, 0, 0, 0};
    vecs[1] = '{OP_RESET, 1'b0, 1'b0, 5+EX, 1'b0, 1'b0, 0, 0, 2, 0};
    vecs[2] = '{OP_SET,   1'b0, 1'b1, 5+EX, 1'b1, 1'b0, 0, 2, 0, 0};
    vecs[3] = '{OP_READ,  1'b0, 1'b0, 2+EX, 1'b1, 1'b1, 0, 0, 0, 5};
    vecs[4] = '{OP_WRITE, 1'b0, 1'b1, 6+EX, 1'b0, 1'b1, 2, 0, 0, 0};
    vecs[5] = '{OP_READ,  1'b1, 1'b0, 2+EX, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[6] = '{OP_SET,   1'b0, 1'b1, 5+EX, 1'b1, 1'b0, 0, 2, 0, 1};

    // Reset asserted with a command offered.
    RSTB = 1'b0; cmd_valid = 1'b1; cmd_op = OP_SET; cmd_d = 1'b1; cmd_exp = 1'b1; rsp_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs",
          {cmd_ready, rsp_valid, rsp_q, rsp_err, LAT_D, LAT_CLK, LAT_SETB, LAT_RSTB},
          8'b1000_0011);
    cmd_valid = 1'b0;
    @(negedge CLK); RSTB = 1'b1;
    @(posedge CLK); #1;
    check("cmd_ready_after_reset", cmd_ready, 1);
    check("rsp_valid_after_reset", rsp_valid, 0);

    for (int i = 0; i < NV; i++) begin
      c0 = clk_hi_n; s0 = setb_lo_n; r0 = rstb_lo_n;
      run_cmd(vecs[i].op, vecs[i].d, vecs[i].exp, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_rsp_q", i), rsp_q, vecs[i].q);
      check($sformatf("v%0d_rsp_err", i), rsp_err, vecs[i].err);
      check($sformatf("v%0d_clk_high_cycles", i), clk_hi_n - c0, vecs[i].clk_w);
      check($sformatf("v%0d_setb_low_cycles", i), setb_lo_n - s0, vecs[i].setb_w);
      check($sformatf("v%0d_rstb_low_cycles", i), rstb_lo_n - r0, vecs[i].rstb_w);
      if (i == 0) begin
        clk_bits = hist_clk[5:0];
        d_bits   = hist_d[5:0];
        check("write_clk_window", clk_bits, 6'b001100);
        check("write_d_window", d_bits, 6'b111110);
      end
      // Hold the response while offering a command that must be ignored.
      cmd_valid = (vecs[i].hold != 0); cmd_op = OP_RESET;
      for (int h = 0; h < vecs[i].hold; h++) begin
        @(posedge CLK); #1;
        check($sformatf("v%0d_hold%0d_stable", i, h),
              {rsp_valid, rsp_q, rsp_err, cmd_ready}, {1'b1, vecs[i].q, vecs[i].err, 1'b0});
      end
      rsp_ready = 1'b1;
      @(posedge CLK); #1;
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      check($sformatf("v%0d_rsp_valid_cleared", i), rsp_valid, 0);
      check($sformatf("v%0d_cmd_ready_back", i), cmd_ready, 1);
      check($sformatf("v%0d_pins_idle", i), {LAT_CLK, LAT_SETB, LAT_RSTB}, 3'b011);
    end

    // Reset during the OPEN phase of a WRITE (latch currently holds 1, D=0 written).
    cmd_op = OP_WRITE; cmd_d = 1'b0; cmd_exp = 1'b0; cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && !LAT_CLK; k++) begin
      @(posedge CLK); #1;
    end
    check("midop_clk_reached", LAT_CLK, 1);
    #2 RSTB = 1'b0;
    #1;
    check("midop_clk_dropped", LAT_CLK, 0);
    check("midop_outputs_reset", {cmd_ready, rsp_valid, LAT_SETB, LAT_RSTB}, 4'b1011);
    @(negedge CLK); @(negedge CLK); RSTB = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (rsp_valid) seen = 1;
    end
    check("midop_no_response", seen, 0);
    run_cmd(OP_READ, 1'b0, 1'b0, lat);
    check("post_reset_read_latency", lat, 2 + EX);
    check("post_reset_read_q", rsp_q, 0);
    check("post_reset_read_err", rsp_err, 0);
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    check("post_reset_read_done", {rsp_valid, cmd_ready}, 2'b01);

    @(negedge CLK);
    check("pin_overlap_cycles", overlap_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
